// File: rtl/mc_datapath_pkg.sv
// mc_datapath_pkg: FSM states, opcode/command constants and condition codes for mc_datapath
package mc_datapath_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH
  } state_t;
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_t;
  // Evaluate a condition code against NZCV; the unused 1111 encoding behaves as always.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (cond_t'(c))
      EQ: return z;
      NE: return ~z;
      CS: return cf;
      CC: return ~cf;
      MI: return n;
      PL: return ~n;
      VS: return v;
      VC: return ~v;
      HI: return cf & ~z;
      LS: return ~cf | z;
      GE: return n == v;
      LT: return n != v;
      GT: return ~z & (n == v);
      LE: return z | (n != v);
      default: return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/mc_datapath_regfile.sv
// mc_regfile: 2-read/1-write register file; the top register reads as the PC alias
module mc_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 16,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  input  logic [XLEN-1:0] pc_alias,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  localparam logic [AW-1:0] PCR = AW'(NREGS - 1);
  logic [XLEN-1:0] regs [NREGS];
  // Storage is deliberately unreset; writes to the PC alias are diverted by the caller.
  always_ff @(posedge clk)
    if (we) regs[wa] <= wd;
  assign rd1 = ra1 == PCR ? pc_alias : regs[ra1];
  assign rd2 = ra2 == PCR ? pc_alias : regs[ra2];
endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle fetch/decode/execute datapath with load/store and branch sequencing.
// Define MC_DATAPATH_COND_EXEC_EN to gate each instruction on its condition code in DECODE.
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 16
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc,
  output logic [3:0]      alu_flags,
  output logic            retire
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] PCR = AW'(NREGS - 1);
`ifdef MC_DATAPATH_COND_EXEC_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif
  state_t state;
  logic [31:0] instr;
  logic [XLEN-1:0] a, b, alu_out, data, rd1, rd2, src_b, bx, res, wd, br_off;
  logic [XLEN:0] sum;
  logic [3:0] flags_q, flags_n, cmd;
  logic [1:0] op;
  logic [AW-1:0] ra2;
  logic sub, logic_op, ovf, go, rd_pc, rf_we;
  assign op  = instr[27:26];
  assign cmd = instr[24:21];
  assign br_off = {{(XLEN - 26){instr[23]}}, instr[23:0], 2'b00};
  mc_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .we       (rf_we),
    .wa       (instr[12 +: AW]),
    .wd       (wd),
    .ra1      (instr[16 +: AW]),
    .ra2      (ra2),
    .pc_alias (pc + XLEN'(4)),
    .rd1      (rd1),
    .rd2      (rd2)
  );
  // ALU: SUB is A + ~B + 1 so C is the ARM-style not-borrow; unknown commands add.
  always_comb begin
    src_b = instr[25] ? XLEN'(instr[11:0]) : b;
    sub = cmd == CMD_SUB;
    logic_op = (cmd == CMD_AND) || (cmd == CMD_ORR);
    bx = sub ? ~src_b : src_b;
    sum = {1'b0, a} + {1'b0, bx} + {{XLEN{1'b0}}, sub};
    res = cmd == CMD_AND ? a & src_b : cmd == CMD_ORR ? a | src_b : sum[XLEN-1:0];
    ovf = (a[XLEN-1] == bx[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
    flags_n = {res[XLEN-1], res == '0, ~logic_op & sum[XLEN], ~logic_op & ovf};
  end
  // Decode-side control, write-back steering and memory/retire outputs decoded from state;
  // reset gates everything so an abandoned access neither requests nor writes.
  always_comb begin
    go = !COND_EN || cond_pass(instr[31:28], alu_flags);
    rd_pc = instr[12 +: AW] == PCR;
    ra2 = op == OP_MEM ? instr[12 +: AW] : instr[0 +: AW];
    wd = state == MEMWB ? data : alu_out;
    rf_we = reset && !rd_pc && (state == ALUWB || state == MEMWB);
    mem_req = reset && (state == FETCH || state == MEMRD || state == MEMWR);
    mem_we = reset && state == MEMWR;
    mem_addr = state == FETCH ? pc : alu_out;
    mem_wdata = b;
    retire = reset && (state == ALUWB || state == MEMWB || state == BRANCH ||
             (state == MEMWR && mem_ready) || (state == DECODE && (!go || op == OP_NOP)));
  end
  // Instruction sequencer; PC-targeted write-backs land in pc instead of the register file.
  always_ff @(posedge clk)
    if (!reset) begin
      state <= FETCH;
      pc <= '0;
      alu_flags <= '0;
      instr <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          instr <= mem_rdata[31:0];
          pc <= pc + XLEN'(4);
          state <= DECODE;
        end
        DECODE: begin
          a <= rd1;
          b <= rd2;
          state <= !go ? FETCH : op == OP_DP ? EXEC : op == OP_MEM ? MEMADR : op == OP_BR ? BRANCH : FETCH;
        end
        EXEC: begin
          alu_out <= res;
          flags_q <= flags_n;
          state <= ALUWB;
        end
        ALUWB: begin
          if (instr[20]) alu_flags <= flags_q;
          if (rd_pc) pc <= alu_out;
          state <= FETCH;
        end
        MEMADR: begin
          alu_out <= a + XLEN'(instr[11:0]);
          state <= instr[20] ? MEMRD : MEMWR;
        end
        MEMRD: if (mem_ready) begin
          data <= mem_rdata;
          state <= MEMWB;
        end
        MEMWB: begin
          if (rd_pc) pc <= data;
          state <= FETCH;
        end
        MEMWR: if (mem_ready) state <= FETCH;
        BRANCH: begin
          pc <= pc + XLEN'(4) + br_off;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed program-level checks of mc_datapath with a wait-state memory model
module tb_mc_datapath;
  localparam logic [3:0] C_AL = 4'hE, C_EQ = 4'h0, C_NE = 4'h1;
  localparam logic [3:0] K_AND = 4'b0000, K_SUB = 4'b0010, K_ADD = 4'b0100, K_ORR = 4'b1100, K_EOR = 4'b0001;
  typedef struct {
    logic [3:0] cmd;
    logic s;
    logic [31:0] a, b, res;
    logic [3:0] nzcv;
  } vec_t;
  logic clk = 1'b0, reset = 1'b0;
  logic mem_req, mem_we, retire, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, pc, mem_rdata = '0;
  logic [3:0] alu_flags;
  logic req64, we64, retire64, ready64 = 1'b0;
  logic [63:0] addr64, wdata64, pc64, rdata64 = '0;
  logic [3:0] flags64;
  logic [31:0] mem [256];
  logic [31:0] mem64 [256];
  logic [31:0] wr_addr[$], wr_data[$];
  int ivl[$], e[$];
  int total = 0, bad = 0, wait_n = 0, cnt = 0, cyc = 0, last = 0;
  vec_t vt[13];
  always #5 clk = ~clk;
  mc_datapath dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .alu_flags(alu_flags), .retire(retire)
  );
  mc_datapath #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .mem_req(req64), .mem_we(we64), .mem_addr(addr64),
    .mem_wdata(wdata64), .mem_rdata(rdata64), .mem_ready(ready64), .pc(pc64),
    .alu_flags(flags64), .retire(retire64)
  );
  // Memory model: answers each request after wait_n stall cycles, commits stores and logs them.
  always @(posedge clk) begin
    #2;
    if (mem_req && cnt >= wait_n) begin
      mem_ready = 1'b1;
      mem_rdata = mem[mem_addr[9:2]];
      if (mem_we) begin
        mem[mem_addr[9:2]] = mem_wdata;
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
      end
      cnt = 0;
    end else begin
      mem_ready = 1'b0;
      cnt = mem_req ? cnt + 1 : 0;
    end
  end
  // Zero-wait 64-bit memory built from little-endian 32-bit words.
  always @(posedge clk) begin
    #2;
    ready64 = req64;
    if (req64) begin
      rdata64 = {mem64[addr64[9:2] + 8'd1], mem64[addr64[9:2]]};
      if (we64) begin
        mem64[addr64[9:2]] = wdata64[31:0];
        mem64[addr64[9:2] + 8'd1] = wdata64[63:32];
      end
    end
  end
  // Cycle counter from reset release and log of cycles between retire pulses.
  always @(negedge clk)
    if (!reset) begin
      cyc = 0;
      last = 0;
    end else begin
      cyc++;
      if (retire) begin
        ivl.push_back(cyc - last);
        last = cyc;
      end
    end
  function automatic logic [31:0] dp(input logic [3:0] cond, input logic [3:0] cmd, input logic i,
                                     input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                     input logic [11:0] op2);
    return {cond, 2'b00, i, cmd, s, rn, rd, op2};
  endfunction
  function automatic logic [31:0] ldst(input logic l, input logic [3:0] rd, input logic [11:0] imm);
    return {C_AL, 2'b01, 1'b0, 4'b1100, l, 4'd0, rd, imm};
  endfunction
  function automatic logic [31:0] br(input logic [23:0] off);
    return {C_AL, 2'b10, 2'b10, off};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_ivl(input string tag, input int q[$]);
    for (int k = 0; k < q.size(); k++)
      chk($sformatf("%s retire interval %0d", tag, k), k < ivl.size() ? 64'(ivl[k]) : '1, 64'(q[k]));
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic rst_on();
    @(posedge clk);
    #1 reset = 1'b0;
    foreach (mem[i]) mem[i] = '0;
    wr_addr.delete();
    wr_data.delete();
  endtask
  task automatic go(input int w);
    wait_n = w;
    ivl.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_req", mem_req, 0);
    chk("reset pc", pc, 0);
    chk("reset flags", alu_flags, 0);
    chk("reset retire", retire, 0);
    reset = 1'b1;
  endtask
  initial begin
    vt[0]  = '{K_ADD, 1'b1, 32'd1,         32'd2,         32'd3,         4'b0000};
    vt[1]  = '{K_ADD, 1'b1, 32'hFFFF_FFFF, 32'd1,         32'd0,         4'b0110};
    vt[2]  = '{K_ADD, 1'b1, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 4'b1001};
    vt[3]  = '{K_SUB, 1'b1, 32'd5,         32'd5,         32'd0,         4'b0110};
    vt[4]  = '{K_SUB, 1'b1, 32'd3,         32'd5,         32'hFFFF_FFFE, 4'b1000};
    vt[5]  = '{K_SUB, 1'b1, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b0011};
    vt[6]  = '{K_AND, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000};
    vt[7]  = '{K_ORR, 1'b1, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 4'b0000};
    vt[8]  = '{K_AND, 1'b1, 32'd1,         32'd2,         32'd0,         4'b0100};
    vt[9]  = '{K_ADD, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0,         4'b0000};
    vt[10] = '{K_EOR, 1'b1, 32'd6,         32'd7,         32'd13,        4'b0000};
    vt[11] = '{K_ORR, 1'b1, 32'h8000_0000, 32'd0,         32'h8000_0000, 4'b1000};
    vt[12] = '{K_SUB, 1'b0, 32'd10,        32'd3,         32'd7,         4'b0000};
    foreach (mem64[i]) mem64[i] = '0;
    mem64[0] = dp(C_AL, K_AND, 1'b1, 1'b0, 4'd0, 4'd0, 12'd0);
    mem64[1] = ldst(1'b1, 4'd1, 12'h100);
    mem64[2] = dp(C_AL, K_ADD, 1'b1, 1'b1, 4'd1, 4'd2, 12'd1);
    mem64[3] = ldst(1'b0, 4'd2, 12'h108);
    mem64[4] = br(24'hFFFFFE);
    mem64[64] = 32'hFFFF_FFFF;
    mem64[66] = 32'hDEAD_BEEF;
    mem64[67] = 32'hDEAD_BEEF;
    // ALU table: operands loaded from memory, result stored back, flags read directly.
    for (int k = 0; k < 13; k++) begin
      rst_on();
      mem[0] = dp(C_AL, K_AND, 1'b1, 1'b0, 4'd0, 4'd0, 12'd0);
      mem[1] = ldst(1'b1, 4'd1, 12'h100);
      mem[2] = ldst(1'b1, 4'd2, 12'h104);
      mem[3] = dp(C_AL, vt[k].cmd, 1'b0, vt[k].s, 4'd1, 4'd3, 12'd2);
      mem[4] = ldst(1'b0, 4'd3, 12'h108);
      mem[5] = br(24'hFFFFFE);
      mem[64] = vt[k].a;
      mem[65] = vt[k].b;
      mem[66] = 32'hDEAD_BEEF;
      go(0);
      repeat (40) tick();
      chk($sformatf("vec%0d result", k), mem[66], vt[k].res);
      chk($sformatf("vec%0d flags", k), alu_flags, vt[k].nzcv);
    end
    // ADD / SUBS / STR / self-branch at 0x10, zero wait states.
    rst_on();
    mem[0] = dp(C_AL, K_AND, 1'b1, 1'b0, 4'd0, 4'd0, 12'd0);
    mem[1] = dp(C_AL, K_ADD, 1'b1, 1'b0, 4'd0, 4'd1, 12'd5);
    mem[2] = dp(C_AL, K_SUB, 1'b1, 1'b1, 4'd1, 4'd2, 12'd5);
    mem[3] = ldst(1'b0, 4'd2, 12'h080);
    mem[4] = br(24'hFFFFFE);
    mem[32] = 32'hDEAD_BEEF;
    go(0);
    tick();
    chk("first cycle pc", pc, 0);
    chk("first cycle mem_req", mem_req, 1);
    chk("first cycle mem_addr", mem_addr, 0);
    chk("first cycle mem_we", mem_we, 0);
    tick();
    chk("decode mem_req", mem_req, 0);
    repeat (15) tick();
    chk("branch fetch pc", pc, 32'h10);
    chk("branch fetch addr", mem_addr, 32'h10);
    repeat (3) tick();
    chk("branch target pc", pc, 32'h10);
    chk("branch target addr", mem_addr, 32'h10);
    repeat (10) tick();
    chk("subs R2", mem[32], 0);
    chk("subs flags", alu_flags, 4'b0110);
    e = '{4, 4, 4, 4, 3, 3};
    check_ivl("dp", e);
    // STR then LDR through three wait states per access.
    for (int w = 3; w >= 0; w -= 3) begin
      rst_on();
      mem[0] = dp(C_AL, K_AND, 1'b1, 1'b0, 4'd0, 4'd0, 12'd0);
      mem[1] = dp(C_AL, K_ADD, 1'b1, 1'b0, 4'd0, 4'd1, 12'd5);
      mem[2] = ldst(1'b0, 4'd1, 12'h008);
      mem[3] = ldst(1'b1, 4'd3, 12'h008);
      mem[4] = ldst(1'b0, 4'd3, 12'h084);
      mem[5] = br(24'hFFFFFE);
      mem[33] = 32'hDEAD_BEEF;
      go(w);
      if (w == 3) begin
        for (int c = 1; c <= 4; c++) begin
          tick();
          chk($sformatf("stall%0d mem_req", c), mem_req, 1);
          chk($sformatf("stall%0d mem_addr", c), mem_addr, 0);
          chk($sformatf("stall%0d pc", c), pc, 0);
        end
        tick();
        chk("after stall pc", pc, 4);
        e = '{7, 7, 10, 11, 10, 6};
      end else e = '{4, 4, 4, 5, 4, 3};
      repeat (60) tick();
      chk($sformatf("w%0d store addr", w), wr_addr.size() > 0 ? wr_addr[0] : '1, 8);
      chk($sformatf("w%0d store data", w), wr_data.size() > 0 ? wr_data[0] : '1, 5);
      chk($sformatf("w%0d ldr R3", w), mem[33], 5);
      check_ivl($sformatf("mem w%0d", w), e);
    end
    // Conditional execution after SUBS sets Z.
    rst_on();
    mem[0] = dp(C_AL, K_AND, 1'b1, 1'b0, 4'd0, 4'd0, 12'd0);
    mem[1] = dp(C_AL, K_ADD, 1'b1, 1'b0, 4'd0, 4'd4, 12'd7);
    mem[2] = dp(C_AL, K_ADD, 1'b1, 1'b0, 4'd0, 4'd1, 12'd5);
    mem[3] = dp(C_AL, K_SUB, 1'b1, 1'b1, 4'd1, 4'd2, 12'd5);
    mem[4] = dp(C_NE, K_ADD, 1'b1, 1'b1, 4'd0, 4'd4, 12'd1);
    mem[5] = dp(C_EQ, K_ADD, 1'b1, 1'b0, 4'd0, 4'd5, 12'd9);
    mem[6] = ldst(1'b0, 4'd4, 12'h088);
    mem[7] = ldst(1'b0, 4'd5, 12'h08C);
    mem[8] = br(24'hFFFFFE);
    mem[34] = 32'hDEAD_BEEF;
    mem[35] = 32'hDEAD_BEEF;
    go(0);
    repeat (50) tick();
    chk("cond R5", mem[35], 9);
`ifdef MC_DATAPATH_COND_EXEC_EN
    chk("cond R4", mem[34], 7);
    chk("cond flags", alu_flags, 4'b0110);
    e = '{4, 4, 4, 4, 2, 4, 4, 4, 3};
`else
    chk("cond R4", mem[34], 1);
    chk("cond flags", alu_flags, 4'b0000);
    e = '{4, 4, 4, 4, 4, 4, 4, 4, 3};
`endif
    check_ivl("cond", e);
    // The 64-bit instance reran its program after every reset release above.
    chk("x64 sum low", mem64[66], 0);
    chk("x64 sum high", mem64[67], 1);
    chk("x64 flags", flags64, 4'b0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
